load_ext_ctrl: RTL and testbench

Load-extension controller for the data-memory read path. Accepts one load request (LB/LH/LW/LBU/LHU) from the core, performs a handshaked word read from data memory, selects the addressed byte or halfword, and drives the shared 16-to-32 extender (X/Se/Y) with the correct sign/zero mode. It returns the 32-bit load result with a done pulse. It sits between the core's memory stage and data memory, and owns the extender's select input whenever a load is in flight.

---
 rtl/load_ext_ctrl.sv | 174 +++++++++++++++++
 tb/tb_load_ext_ctrl.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/load_ext_ctrl.sv
// Load-extension controller: one handshaked word read per load, then byte/halfword
// selection through the shared 16-to-32 extender, returning the result with a Done pulse.
module load_ext_ctrl #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        Req,
  input  logic [2:0]  Op,
  input  logic [31:0] Addr,
  output logic        Busy,
  output logic        MemRd,
  output logic [31:0] MemAddr,
  input  logic        MemAck,
  input  logic [31:0] MemData,
  output logic [15:0] ExtX,
  output logic        ExtSe,
  input  logic [31:0] ExtY,
  output logic        Done,
  output logic [31:0] Data,
  output logic        Err,
  output logic [1:0]  dbg_state
);

  // Handshake: a read is in flight while MemRd=1; one cycle with MemAck=1 transfers
  // MemData and ends the read. MemAck in any other cycle is ignored.

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_READ = 2'd1,
    S_EXT  = 2'd2
  } state_t;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [2:0]  op_q, op_d;
  logic [1:0]  addr_lo_q, addr_lo_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] word_q, word_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [31:0] data_q, data_d;
  logic        done_q, done_d;
  logic        err_q, err_d;

  logic        req_ok;
  logic        timeout_hit;
  logic [7:0]  sel_byte;

  // Legal opcode and natural alignment of the incoming request.
  always_comb begin
    req_ok = 1'b0;
    case (Op)
      3'b000, 3'b100: req_ok = 1'b1;
      3'b001, 3'b101: req_ok = ~Addr[0];
      3'b011:         req_ok = (Addr[1:0] == 2'b00);
      default:        req_ok = 1'b0;
    endcase
  end

  assign timeout_hit = (cnt_q == CNT_LAST);

  // State register
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q    <= S_IDLE;
      op_q       <= 3'b000;
      addr_lo_q  <= 2'b00;
      mem_addr_q <= 32'h0;
      word_q     <= 32'h0;
      cnt_q      <= 8'h0;
      data_q     <= 32'h0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      addr_lo_q  <= addr_lo_d;
      mem_addr_q <= mem_addr_d;
      word_q     <= word_d;
      cnt_q      <= cnt_d;
      data_q     <= data_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (Req && req_ok) state_d = S_READ;
      S_READ: begin
        if (MemAck)           state_d = S_EXT;
        else if (timeout_hit) state_d = S_IDLE;
      end
      S_EXT:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath registers and the registered Done/Err pulses
  always_comb begin
    op_d       = op_q;
    addr_lo_d  = addr_lo_q;
    mem_addr_d = mem_addr_q;
    word_d     = word_q;
    cnt_d      = cnt_q;
    data_d     = data_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (Req) begin
          if (req_ok) begin
            op_d       = Op;
            addr_lo_d  = Addr[1:0];
            mem_addr_d = {Addr[31:2], 2'b00};
            cnt_d      = 8'h0;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_READ: begin
        if (MemAck) begin
          word_d = MemData;
        end else if (timeout_hit) begin
          err_d = 1'b1;
          cnt_d = 8'h0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_EXT: begin
        data_d = op_q[1] ? word_q : ExtY;
        done_d = 1'b1;
      end
      default: ;
    endcase
  end

  // Big-endian byte lanes: lane 0 is the most significant byte.
  always_comb begin
    sel_byte = 8'h00;
    case (addr_lo_q)
      2'd0: sel_byte = word_q[31:24];
      2'd1: sel_byte = word_q[23:16];
      2'd2: sel_byte = word_q[15:8];
      2'd3: sel_byte = word_q[7:0];
      default: sel_byte = 8'h00;
    endcase
  end

  // Output decode
  always_comb begin
    Busy  = (state_q != S_IDLE);
    MemRd = (state_q == S_READ);
    ExtX  = 16'h0;
    ExtSe = 1'b0;
    if (state_q == S_EXT && !op_q[1]) begin
      ExtSe = ~op_q[2];
      if (op_q[0]) ExtX = addr_lo_q[1] ? word_q[15:0] : word_q[31:16];
      else         ExtX = {{8{~op_q[2] & sel_byte[7]}}, sel_byte};
    end
  end

  assign MemAddr   = mem_addr_q;
  assign Data      = data_q;
  assign Done      = done_q;
  assign Err       = err_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_load_ext_ctrl.sv
// Bench for load_ext_ctrl: directed and random loads scored through an expected-data
// queue, plus request errors, timeout and mid-read reset.
module tb_load_ext_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req;
  logic [2:0]  op;
  logic [31:0] addr;
  logic        busy, mem_rd, mem_ack;
  logic [31:0] mem_addr, mem_data;
  logic [15:0] ext_x;
  logic        ext_se;
  logic [31:0] ext_y;
  logic        done, err;
  logic [31:0] data;
  logic [1:0]  dbg_state;

  int checks = 0;
  int failures = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  logic [31:0] exp_q[$];
  logic [31:0] mon_exp;

  load_ext_ctrl #(.TIMEOUT(15)) dut (
    .Clk(clk), .Rst(rst), .Req(req), .Op(op), .Addr(addr),
    .Busy(busy), .MemRd(mem_rd), .MemAddr(mem_addr),
    .MemAck(mem_ack), .MemData(mem_data),
    .ExtX(ext_x), .ExtSe(ext_se), .ExtY(ext_y),
    .Done(done), .Data(data), .Err(err), .dbg_state(dbg_state)
  );

  // Clock
  always #5 clk = ~clk;

  // Shared 16-to-32 extender
  assign ext_y = ext_se ? {{16{ext_x[15]}}, ext_x} : {16'h0, ext_x};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] model_extx(input logic [2:0] o, input logic [31:0] a,
                                             input logic [31:0] w);
    logic [7:0] b;
    if (o == 3'b011) return 16'h0;
    if (o == 3'b000 || o == 3'b100) begin
      b = 8'(w >> (8 * (3 - int'(a[1:0]))));
      return {((o == 3'b000) && b[7]) ? 8'hFF : 8'h00, b};
    end
    return a[1] ? w[15:0] : w[31:16];
  endfunction

  function automatic logic [31:0] model_data(input logic [2:0] o, input logic [31:0] a,
                                             input logic [31:0] w);
    logic [15:0] x;
    if (o == 3'b011) return w;
    x = model_extx(o, a, w);
    return (o[2] == 1'b0) ? {{16{x[15]}}, x} : {16'h0, x};
  endfunction

  // Scoreboard monitor
  always @(negedge clk) begin
    if (!rst) begin
      if (done) begin
        done_cnt++;
        if (exp_q.size() == 0) begin
          check("unexpected_done", 32'(done), 32'h0);
        end else begin
          mon_exp = exp_q.pop_front();
          check("data", data, mon_exp);
        end
      end
      if (err) err_cnt++;
      if (done || err) check("done_err_excl", 32'(done & err), 32'h0);
    end
  end

  // Issue one load; caller is between posedge+1 and the next posedge.
  task automatic do_load(input logic [2:0] o, input logic [31:0] a, input logic [31:0] w,
                         input int delay, input logic [31:0] exp_data,
                         input logic [15:0] exp_x);
    logic exp_se;
    exp_se = (o == 3'b011) ? 1'b0 : ~o[2];
    req = 1'b1; op = o; addr = a;
    exp_q.push_back(exp_data);
    @(posedge clk); #1;
    req = 1'b0;
    for (int i = 1; i <= delay; i++) begin
      mem_ack  = (i == delay);
      mem_data = (i == delay) ? w : $urandom;
      @(negedge clk);
      check("memrd", 32'(mem_rd), 32'h1);
      check("memaddr", mem_addr, {a[31:2], 2'b00});
      @(posedge clk); #1;
    end
    mem_ack = 1'b0;
    @(negedge clk);
    check("ext_x", 32'(ext_x), 32'(exp_x));
    check("ext_se", 32'(ext_se), 32'(exp_se));
    check("busy_ext", 32'(busy), 32'h1);
    @(posedge clk); #1;
    @(negedge clk);
    check("done_pulse", 32'(done), 32'h1);
  endtask

  task automatic req_err(input logic [2:0] o, input logic [31:0] a);
    logic [31:0] d0;
    d0 = data;
    req = 1'b1; op = o; addr = a;
    @(posedge clk); #1;
    req = 1'b0;
    @(negedge clk);
    check("req_err", 32'(err), 32'h1);
    check("req_err_busy", 32'(busy), 32'h0);
    check("req_err_memrd", 32'(mem_rd), 32'h0);
    check("req_err_data", data, d0);
    @(posedge clk); #1;
    @(negedge clk);
    check("req_err_single", 32'(err), 32'h0);
    @(posedge clk); #1;
  endtask

  initial begin
    int base_done;
    logic [2:0]  r_op;
    logic [31:0] r_addr, r_word;
    logic [2:0]  legal_ops [5];
    legal_ops = '{3'b000, 3'b001, 3'b011, 3'b100, 3'b101};

    // Reset
    rst = 1'b1; req = 1'b0; op = 3'b000; addr = 32'h0; mem_ack = 1'b0; mem_data = 32'h0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_memrd", 32'(mem_rd), 32'h0);
    check("rst_memaddr", mem_addr, 32'h0);
    check("rst_extx", 32'(ext_x), 32'h0);
    check("rst_extse", 32'(ext_se), 32'h0);
    check("rst_done", 32'(done), 32'h0);
    check("rst_data", data, 32'h0);
    check("rst_err", 32'(err), 32'h0);
    check("rst_state", 32'(dbg_state), 32'h0);
    @(posedge clk); #1;

    // Directed loads
    do_load(3'b000, 32'h1001, 32'h12F45678, 1, 32'hFFFFFFF4, 16'hFFF4);
    do_load(3'b100, 32'h1001, 32'h12F45678, 1, 32'h000000F4, 16'h00F4);
    do_load(3'b101, 32'h1002, 32'h1234ABCD, 1, 32'h0000ABCD, 16'hABCD);
    do_load(3'b001, 32'h1000, 32'h1234ABCD, 1, 32'h00001234, 16'h1234);
    do_load(3'b001, 32'h1002, 32'h1234ABCD, 2, 32'hFFFFABCD, 16'hABCD);
    do_load(3'b011, 32'h2000, 32'hDEADBEEF, 4, 32'hDEADBEEF, 16'h0000);
    @(posedge clk); #1;

    // Request errors
    req_err(3'b001, 32'h1001);
    req_err(3'b011, 32'h1002);
    req_err(3'b010, 32'h1000);

    // Timeout with a stale ack afterwards
    base_done = done_cnt;
    req = 1'b1; op = 3'b011; addr = 32'h3000;
    @(posedge clk); #1;
    req = 1'b0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      check("to_memrd", 32'(mem_rd), 32'h1);
      @(posedge clk); #1;
    end
    @(negedge clk);
    check("to_err", 32'(err), 32'h1);
    check("to_memrd_low", 32'(mem_rd), 32'h0);
    check("to_busy", 32'(busy), 32'h0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    mem_ack = 1'b1; mem_data = 32'hCAFEF00D;
    @(posedge clk); #1;
    mem_ack = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("to_no_done", 32'(done_cnt), 32'(base_done));

    // Reset during the second READ cycle with an ack present
    req = 1'b1; op = 3'b000; addr = 32'h1001;
    @(posedge clk); #1;
    req = 1'b0;
    @(posedge clk); #1;
    mem_ack = 1'b1; mem_data = 32'h12F45678; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("mr_busy", 32'(busy), 32'h0);
    check("mr_memrd", 32'(mem_rd), 32'h0);
    check("mr_memaddr", mem_addr, 32'h0);
    check("mr_extx", 32'(ext_x), 32'h0);
    check("mr_done", 32'(done), 32'h0);
    check("mr_data", data, 32'h0);
    check("mr_err", 32'(err), 32'h0);
    @(posedge clk); #1;
    mem_ack = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("mr_no_done", 32'(done_cnt), 32'(base_done));

    // Back-to-back LB requests issued on Done cycles
    do_load(3'b000, 32'h4003, 32'h0102037F, 1, 32'h0000007F, 16'h007F);
    do_load(3'b000, 32'h4000, 32'h80000000, 1, 32'hFFFFFF80, 16'hFF80);
    do_load(3'b000, 32'h4002, 32'h00009900, 1, 32'hFFFFFF99, 16'hFF99);

    // Random legal loads
    for (int n = 0; n < 8; n++) begin
      r_op   = legal_ops[$urandom_range(0, 4)];
      r_addr = $urandom;
      if (r_op == 3'b011) r_addr[1:0] = 2'b00;
      else if (r_op[0])   r_addr[0] = 1'b0;
      r_word = $urandom;
      do_load(r_op, r_addr, r_word, $urandom_range(1, 5),
              model_data(r_op, r_addr, r_word), model_extx(r_op, r_addr, r_word));
    end

    repeat (3) @(posedge clk);
    #1;
    check("queue_empty", 32'(exp_q.size()), 32'h0);
    check("err_count", 32'(err_cnt), 32'd4);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
